// File: rtl/sdr_proto_pkg.sv
`default_nettype none
// ============================================================================
// sdr_proto_pkg : opcodes, port number and encodings shared by the port-1024
//                 command parser and the reply transmitter.
// Rev 1.0
// ============================================================================
package sdr_proto_pkg;

  localparam logic [15:0] GEN_CMD_PORT  = 16'd1024;

  localparam logic [7:0]  OP_DISC_IDLE  = 8'h02;
  localparam logic [7:0]  OP_DISC_RUN   = 8'h03;
  localparam logic [7:0]  OP_ERASE_DONE = 8'h04;
  localparam logic [7:0]  OP_SEND_MORE  = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    SRC_DISC  = 2'd0,
    SRC_ERASE = 2'd1,
    SRC_MORE  = 2'd2
  } reply_src_e;

  function automatic logic [7:0] reply_opcode(input reply_src_e src, input logic run);
    case (src)
      SRC_ERASE: reply_opcode = OP_ERASE_DONE;
      SRC_MORE:  reply_opcode = OP_SEND_MORE;
      default:   reply_opcode = run ? OP_DISC_RUN : OP_DISC_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_req_latch.sv
`default_nettype none
// ============================================================================
// sdr_req_latch : rising-edge capture of a level request into a pending flag,
//                 with a one-cycle acknowledge the cycle after the edge.
// Rev 1.0
// ============================================================================
module sdr_req_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic clr_i,
  output logic pend_o,
  output logic ack_o,
  output logic rise_o
);

  logic req_q;
  logic pend_q, pend_d;
  logic ack_q;

  assign rise_o = req_i & ~req_q;

  // A new edge wins over a same-cycle clear so it is never lost.
  always_comb begin
    pend_d = pend_q;
    if (clr_i)  pend_d = 1'b0;
    if (rise_o) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
      ack_q  <= rise_o;
    end
  end

  assign pend_o = pend_q;
  assign ack_o  = ack_q;

endmodule
`default_nettype wire

// File: rtl/sdr_reply_tx.sv
`default_nettype none
// ============================================================================
// sdr_reply_tx : latches reply requests, arbitrates them and streams one
//                fixed-length UDP payload per reply to the UDP transmit mux.
// Rev 1.0
// ============================================================================
module sdr_reply_tx #(
  parameter int          PAYLOAD_LEN = 60,
  parameter logic [7:0]  BOARD_ID    = 8'h05,
  parameter logic [7:0]  PROTO_VER   = 8'd38,
  parameter int          GAP_CYCLES  = 12,
  parameter int          GRANT_TOUT  = 1024
) (
  input  logic        tx_clock_i,
  input  logic        reset_i,
  input  logic        discovery_reply_i,
  input  logic        erase_done_i,
  input  logic        send_more_i,
  input  logic        run_i,
  input  logic [31:0] sequence_number_i,
  input  logic [47:0] local_mac_i,
  input  logic [7:0]  code_version_i,
  input  logic        udp_tx_grant_i,
  output logic        discovery_ACK_o,
  output logic        erase_ACK_o,
  output logic        send_more_ACK_o,
  output logic        sending_sync_o,
  output logic        udp_tx_request_o,
  output logic [7:0]  udp_tx_data_o,
  output logic        udp_tx_valid_o
);
  import sdr_proto_pkg::*;

  localparam int         TW        = (GRANT_TOUT > 1) ? $clog2(GRANT_TOUT) : 1;
  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(GRANT_TOUT - 1);

  tx_state_e   state_q, state_d;
  reply_src_e  sel_q, sel_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] tout_cnt_q, tout_cnt_d;

  logic [31:0] seq_hold_q;
  logic [31:0] seq_snap_q;
  logic [7:0]  op_snap_q;
  logic [47:0] mac_snap_q;
  logic [7:0]  ver_snap_q;

  logic w_disc_pend, w_erase_pend, w_more_pend;
  logic w_disc_rise, w_erase_rise, w_more_rise;
  logic w_unused_rise;
  logic w_snap;
  logic [7:0] w_byte;

  assign w_snap        = (state_q == ST_REQ) && udp_tx_grant_i;
  assign w_unused_rise = w_disc_rise | w_erase_rise;

  sdr_req_latch u_disc (
    .clk_i (tx_clock_i), .rst_i (reset_i), .req_i (discovery_reply_i),
    .clr_i (w_snap && (sel_q == SRC_DISC)),
    .pend_o(w_disc_pend), .ack_o(discovery_ACK_o), .rise_o(w_disc_rise)
  );

  sdr_req_latch u_erase (
    .clk_i (tx_clock_i), .rst_i (reset_i), .req_i (erase_done_i),
    .clr_i (w_snap && (sel_q == SRC_ERASE)),
    .pend_o(w_erase_pend), .ack_o(erase_ACK_o), .rise_o(w_erase_rise)
  );

  sdr_req_latch u_more (
    .clk_i (tx_clock_i), .rst_i (reset_i), .req_i (send_more_i),
    .clr_i (w_snap && (sel_q == SRC_MORE)),
    .pend_o(w_more_pend), .ack_o(send_more_ACK_o), .rise_o(w_more_rise)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tout_cnt_d = tout_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tout_cnt_d = '0;
        if (w_erase_pend) begin
          sel_d = SRC_ERASE; state_d = ST_REQ;
        end else if (w_more_pend) begin
          sel_d = SRC_MORE;  state_d = ST_REQ;
        end else if (w_disc_pend) begin
          sel_d = SRC_DISC;  state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (udp_tx_grant_i) begin
          state_d    = ST_SEND;
          byte_cnt_d = 8'd0;
        end else if (tout_cnt_q == TOUT_LAST) begin
          // Give the mux back; the pending flag stays set so we retry after the gap.
          state_d   = ST_GAP;
          gap_cnt_d = 8'd0;
        end else begin
          tout_cnt_d = tout_cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (byte_cnt_q == LAST_BYTE) begin
          state_d    = ST_GAP;
          gap_cnt_d  = 8'd0;
          byte_cnt_d = 8'd0;
        end else begin
          byte_cnt_d = byte_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= SRC_DISC;
      byte_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      tout_cnt_q <= '0;
      seq_hold_q <= 32'd0;
      seq_snap_q <= 32'd0;
      op_snap_q  <= 8'd0;
      mac_snap_q <= 48'd0;
      ver_snap_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tout_cnt_q <= tout_cnt_d;
      if (w_more_rise) seq_hold_q <= sequence_number_i;
      if (w_snap) begin
        seq_snap_q <= (sel_q == SRC_MORE) ? seq_hold_q : 32'd0;
        op_snap_q  <= reply_opcode(sel_q, run_i);
        mac_snap_q <= local_mac_i;
        ver_snap_q <= code_version_i;
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (byte_cnt_q)
      8'd0:  w_byte = seq_snap_q[31:24];
      8'd1:  w_byte = seq_snap_q[23:16];
      8'd2:  w_byte = seq_snap_q[15:8];
      8'd3:  w_byte = seq_snap_q[7:0];
      8'd4:  w_byte = op_snap_q;
      8'd5:  w_byte = mac_snap_q[47:40];
      8'd6:  w_byte = mac_snap_q[39:32];
      8'd7:  w_byte = mac_snap_q[31:24];
      8'd8:  w_byte = mac_snap_q[23:16];
      8'd9:  w_byte = mac_snap_q[15:8];
      8'd10: w_byte = mac_snap_q[7:0];
      8'd11: w_byte = BOARD_ID;
      8'd12: w_byte = PROTO_VER;
      8'd13: w_byte = ver_snap_q;
      default: w_byte = 8'h00;
    endcase
  end

  assign udp_tx_request_o = (state_q == ST_REQ);
  assign sending_sync_o   = (state_q == ST_REQ) || (state_q == ST_SEND);
  assign udp_tx_valid_o   = (state_q == ST_SEND);
  assign udp_tx_data_o    = udp_tx_valid_o ? w_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_sdr_reply_tx.sv
`default_nettype none
// ============================================================================
// tb_sdr_reply_tx : scoreboard bench for sdr_reply_tx.
// Rev 1.0
// ============================================================================
module tb_sdr_reply_tx;

  localparam int PLEN = 60;
  localparam int GAP  = 12;
  localparam int TOUT = 1024;
  localparam int K_DISC = 0, K_ERASE = 1, K_MORE = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        disc = 1'b0, erase = 1'b0, more = 1'b0, run = 1'b0;
  logic [31:0] seqn = 32'd0;
  logic [47:0] mac  = 48'd0;
  logic [7:0]  ver  = 8'd0;
  logic        grant = 1'b0;
  logic        disc_ack, erase_ack, more_ack, sync, req, valid;
  logic [7:0]  data;

  always #5 clk = ~clk;

  sdr_reply_tx dut (
    .tx_clock_i(clk), .reset_i(rst),
    .discovery_reply_i(disc), .erase_done_i(erase), .send_more_i(more),
    .run_i(run), .sequence_number_i(seqn), .local_mac_i(mac), .code_version_i(ver),
    .udp_tx_grant_i(grant),
    .discovery_ACK_o(disc_ack), .erase_ACK_o(erase_ack), .send_more_ACK_o(more_ack),
    .sending_sync_o(sync), .udp_tx_request_o(req), .udp_tx_data_o(data),
    .udp_tx_valid_o(valid)
  );

  int n_cmp = 0, n_bad = 0;
  logic [PLEN*8-1:0] exp_q[$];
  logic [7:0] byteq[$];
  int ack_cnt[3];
  int exp_ack[3];
  int cyc = 0, pkt_cnt = 0, req_rises = 0;
  int last_byte_cyc = 0, req_rise_cyc = 0, req_fall_cyc = 0;
  bit gnt_en = 1'b1;
  int gnt_dly = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference payload straight from the byte-layout rules.
  function automatic logic [PLEN*8-1:0] model(input int kind, input logic [31:0] s,
                                               input logic r, input logic [47:0] m,
                                               input logic [7:0] v);
    logic [PLEN*8-1:0] p;
    logic [7:0] b;
    p = '0;
    for (int i = 0; i < PLEN; i++) begin
      b = 8'h00;
      if (i < 4)        b = (kind == K_MORE) ? 8'(s >> (8 * (3 - i))) : 8'h00;
      else if (i == 4)  b = (kind == K_ERASE) ? 8'h04 : (kind == K_MORE) ? 8'h05 : (r ? 8'h03 : 8'h02);
      else if (i <= 10) b = 8'(m >> (8 * (10 - i)));
      else if (i == 11) b = 8'h05;
      else if (i == 12) b = 8'd38;
      else if (i == 13) b = v;
      p[i*8 +: 8] = b;
    end
    return p;
  endfunction

  // Monitor: counts ACKs, tracks request timing, assembles and scores packets.
  initial begin
    logic pv, pr;
    logic [PLEN*8-1:0] act, expv;
    int diff;
    pv = 1'b0; pr = 1'b0;
    for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        byteq.delete(); pv = 1'b0; pr = 1'b0;
      end else begin
        if (disc_ack)  ack_cnt[K_DISC]++;
        if (erase_ack) ack_cnt[K_ERASE]++;
        if (more_ack)  ack_cnt[K_MORE]++;
        if (req && !pr) begin req_rise_cyc = cyc; req_rises++; end
        if (!req && pr) req_fall_cyc = cyc;
        if (valid) begin
          byteq.push_back(data);
          last_byte_cyc = cyc;
        end else if (pv) begin
          pkt_cnt++;
          chk("pkt_len", 64'(byteq.size()), 64'(PLEN));
          chk("sync_low_after_last", 64'(sync), 64'd0);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pkt: got a %0d-byte packet, expected none", byteq.size());
          end else begin
            expv = exp_q.pop_front();
            act = '0;
            for (int i = 0; i < PLEN && i < byteq.size(); i++) act[i*8 +: 8] = byteq[i];
            if (act !== expv) begin
              n_bad++;
              diff = 0;
              for (int i = PLEN - 1; i >= 0; i--) if (act[i*8 +: 8] !== expv[i*8 +: 8]) diff = i;
              $display("FAIL pkt_data: byte %0d got %02h expected %02h", diff,
                       act[diff*8 +: 8], expv[diff*8 +: 8]);
            end
          end
          byteq.delete();
        end
        pv = valid; pr = req;
      end
    end
  end

  // UDP-layer model: grants gnt_dly cycles after request is seen.
  initial begin
    int gcnt;
    gcnt = 0;
    forever begin
      @(negedge clk);
      grant = 1'b0;
      if (gnt_en && req && !rst) begin
        if (gcnt >= gnt_dly) begin grant = 1'b1; gcnt = 0; end
        else gcnt++;
      end else gcnt = 0;
    end
  end

  function automatic logic ack_of(input int kind);
    return (kind == K_DISC) ? disc_ack : (kind == K_ERASE) ? erase_ack : more_ack;
  endfunction

  task automatic set_req(input int kind, input logic v);
    if (kind == K_DISC) disc = v; else if (kind == K_ERASE) erase = v; else more = v;
  endtask

  task automatic pulse_req(input int kind, input int hold);
    set_req(kind, 1'b1);
    exp_ack[kind]++;
    @(negedge clk);
    chk("ack_next_cycle", 64'(ack_of(kind)), 64'd1);
    repeat (hold - 1) @(negedge clk);
    set_req(kind, 1'b0);
  endtask

  task automatic push_exp(input int kind);
    exp_q.push_back(model(kind, seqn, run, mac, ver));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!valid && n < budget) begin @(negedge clk); #1; n++; end
    chk("valid_within_budget", 64'(valid), 64'd1);
  endtask

  task automatic wait_req(input logic lvl, input int budget);
    int n = 0;
    while (req !== lvl && n < budget) begin @(negedge clk); #1; n++; end
    chk("request_level_within_budget", 64'(req), 64'(lvl));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || sync || valid) && n < budget) begin @(negedge clk); #1; n++; end
    chk("drained_within_budget", 64'(exp_q.size() == 0 && !sync), 64'd1);
    repeat (GAP + 4) @(negedge clk);
  endtask

  task automatic scramble();
    seqn = $urandom; mac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    ver = 8'($urandom); run = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int p0, r0, l0, f0, kind;
    for (int k = 0; k < 3; k++) exp_ack[k] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({valid, req, sync, disc_ack, erase_ack, more_ack, data}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Discovery, idle radio, grant after 3 cycles.
    run = 1'b0; mac = 48'h00_1C_C0_A2_13_5E; ver = 8'd21; gnt_dly = 3;
    push_exp(K_DISC);
    pulse_req(K_DISC, 2);
    wait_drain(300);

    // Send-more with sequence number changing mid-packet.
    seqn = 32'h1234_5678; mac = 48'hA1B2_C3D4_E5F6; ver = 8'h7E; gnt_dly = 1;
    push_exp(K_MORE);
    pulse_req(K_MORE, 4);
    wait_valid(50);
    scramble();
    wait_drain(300);

    // Simultaneous erase and discovery: erase first, then discovery after the gap.
    run = 1'b1; mac = 48'h0203_0405_0607; ver = 8'h11; gnt_dly = 0;
    push_exp(K_ERASE);
    push_exp(K_DISC);
    erase = 1'b1; disc = 1'b1; exp_ack[K_ERASE]++; exp_ack[K_DISC]++;
    @(negedge clk);
    chk("erase_ack_next_cycle", 64'(erase_ack), 64'd1);
    chk("disc_ack_next_cycle", 64'(disc_ack), 64'd1);
    @(negedge clk);
    erase = 1'b0; disc = 1'b0;
    wait_valid(50);
    while (valid) begin @(negedge clk); #1; end
    l0 = last_byte_cyc;
    wait_req(1'b1, 40);
    chk("gap_before_next_request", 64'(req_rise_cyc - l0), 64'(GAP + 2));
    wait_drain(300);

    // Grant timeout then retry.
    gnt_en = 1'b0; run = 1'b0; mac = 48'hDEAD_BEEF_0001; ver = 8'h42;
    push_exp(K_DISC);
    pulse_req(K_DISC, 2);
    wait_req(1'b1, 10);
    r0 = req_rise_cyc;
    wait_req(1'b0, TOUT + 20);
    chk("request_held_for_timeout", 64'(req_fall_cyc - r0), 64'(TOUT));
    f0 = req_fall_cyc;
    gnt_en = 1'b1; gnt_dly = 2;
    p0 = pkt_cnt;
    wait_req(1'b1, GAP + 20);
    chk("retry_after_gap", 64'(req_rise_cyc - f0), 64'(GAP + 1));
    wait_drain(300);
    chk("one_packet_after_retry", 64'(pkt_cnt - p0), 64'd1);

    // Reset in the middle of a packet.
    mac = 48'h5555_AAAA_0F0F; ver = 8'h03; gnt_dly = 1;
    push_exp(K_DISC);
    pulse_req(K_DISC, 2);
    begin
      int n = 0;
      while (byteq.size() < 20 && n < 200) begin @(negedge clk); #1; n++; end
    end
    chk("reached_byte_20", 64'(byteq.size()), 64'd20);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", 64'({valid, req, sync}), 64'd0);
    void'(exp_q.pop_back());
    r0 = req_rises;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_pending_after_reset", 64'(req_rises - r0), 64'd0);
    push_exp(K_DISC);
    pulse_req(K_DISC, 2);
    wait_drain(300);

    // Two discovery edges during SEND merge into one further packet.
    p0 = pkt_cnt;
    push_exp(K_DISC);
    push_exp(K_DISC);
    pulse_req(K_DISC, 2);
    wait_valid(50);
    repeat (2) begin
      pulse_req(K_DISC, 2);
      repeat (2) @(negedge clk);
    end
    wait_drain(400);
    chk("merged_packets", 64'(pkt_cnt - p0), 64'd2);

    // Randomized single requests with random data and grant latency.
    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 2);
      scramble();
      gnt_dly = $urandom_range(0, 20);
      push_exp(kind);
      pulse_req(kind, $urandom_range(1, 5));
      wait_valid(80);
      scramble();
      wait_drain(300);
    end

    chk("disc_ack_count",  64'(ack_cnt[K_DISC]),  64'(exp_ack[K_DISC]));
    chk("erase_ack_count", 64'(ack_cnt[K_ERASE]), 64'(exp_ack[K_ERASE]));
    chk("more_ack_count",  64'(ack_cnt[K_MORE]),  64'(exp_ack[K_MORE]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
